// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch/issue sequencer. Walks a program counter through an
//   external combinational instruction memory, latches each word, hands it to
//   an execute stage with a one-cycle valid pulse, and waits for the execute
//   stage before fetching again (sequentially or via a jump).
//
// Ports
//   clk            in   system clock, all state changes on rising edge
//   reset          in   synchronous active-high reset
//   start          in   begin execution at address 0 (only in IDLE/HALTED)
//   programSelect  in   [7:0]  program-select switches, sampled on accepted start
//   selectLatched  out  [7:0]  captured programSelect, instruction memory select
//   address        out  [7:0]  program counter / instruction memory address
//   instruction    in   [15:0] instruction memory word at address
//   instructionReg out  [15:0] latched instruction for the execute stage
//   instrValid     out  one-cycle pulse, instructionReg valid
//   execDone       in   execute stage finished current instruction
//   jumpTaken      in   redirect PC to jumpTarget (qualified by execDone)
//   jumpTarget     in   [7:0]  jump destination
//   busy           out  sequencer in FETCH/ISSUE/WAIT
//   halted         out  program ended (HALT opcode, PC overflow or null select)
//   fault          out  abnormal end (PC overflow or null select)
//   instrCount     out  [7:0]  issued instructions, saturating at 255
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  programSelect,
  output logic [7:0]  selectLatched,
  output logic [7:0]  address,
  input  logic [15:0] instruction,
  output logic [15:0] instructionReg,
  output logic        instrValid,
  input  logic        execDone,
  input  logic        jumpTaken,
  input  logic [7:0]  jumpTarget,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [7:0]  instrCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    HALTED = 3'd4
  } stateType;

  localparam logic [3:0] HALT_OP  = 4'b1110;
  localparam logic [7:0] LAST_PC  = 8'hFF;
  localparam logic [7:0] MAX_COUNT = 8'hFF;

  stateType    state;
  stateType    stateNext;
  logic [7:0]  addressNext;
  logic [7:0]  selectNext;
  logic [15:0] instrRegNext;
  logic [7:0]  countNext;
  logic        haltedNext;
  logic        faultNext;

  // Next-state and next-datapath decode for the sequencer FSM.
  always_comb begin
    stateNext    = state;
    addressNext  = address;
    selectNext   = selectLatched;
    instrRegNext = instructionReg;
    countNext    = instrCount;
    haltedNext   = halted;
    faultNext    = fault;

    case (state)
      IDLE, HALTED: begin
        if (start) begin
          selectNext  = programSelect;
          addressNext = 8'd0;
          countNext   = 8'd0;
          if (programSelect == 8'd0) begin
            // A null program select is refused outright: no fetch happens.
            stateNext  = HALTED;
            haltedNext = 1'b1;
            faultNext  = 1'b1;
          end else begin
            stateNext  = FETCH;
            haltedNext = 1'b0;
            faultNext  = 1'b0;
          end
        end else begin
          stateNext = state;
        end
      end

      FETCH: begin
        // The word is latched even when it is HALT, so it remains observable.
        instrRegNext = instruction;
        if (instruction[15:12] == HALT_OP) begin
          stateNext  = HALTED;
          haltedNext = 1'b1;
        end else begin
          stateNext = ISSUE;
        end
      end

      ISSUE: begin
        stateNext = WAIT;
        if (instrCount != MAX_COUNT) begin
          countNext = instrCount + 8'd1;
        end else begin
          countNext = instrCount;
        end
      end

      WAIT: begin
        if (execDone) begin
          if (jumpTaken) begin
            addressNext = jumpTarget;
            stateNext   = FETCH;
          end else if (address != LAST_PC) begin
            addressNext = address + 8'd1;
            stateNext   = FETCH;
          end else begin
            // Running off the end of memory is an error; the PC does not wrap.
            stateNext  = HALTED;
            haltedNext = 1'b1;
            faultNext  = 1'b1;
          end
        end else begin
          stateNext = WAIT;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; busy/instrValid are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      address        <= 8'd0;
      selectLatched  <= 8'd0;
      instructionReg <= 16'd0;
      instrCount     <= 8'd0;
      halted         <= 1'b0;
      fault          <= 1'b0;
      instrValid     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= stateNext;
      address        <= addressNext;
      selectLatched  <= selectNext;
      instructionReg <= instrRegNext;
      instrCount     <= countNext;
      halted         <= haltedNext;
      fault          <= faultNext;
      instrValid     <= (stateNext == ISSUE);
      busy           <= (stateNext == FETCH) || (stateNext == ISSUE) || (stateNext == WAIT);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Randomised, scoreboard-checked bench for fetch_sequencer. A behavioural
//   program walker predicts the issued instruction stream and final status;
//   a monitor compares every instrValid pulse against the predicted stream.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  programSelect;
  logic [7:0]  selectLatched;
  logic [7:0]  address;
  logic [15:0] instruction;
  logic [15:0] instructionReg;
  logic        instrValid;
  logic        execDone;
  logic        jumpTaken;
  logic [7:0]  jumpTarget;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [7:0]  instrCount;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  assign instruction = mem[address];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .programSelect (programSelect),
    .selectLatched (selectLatched),
    .address       (address),
    .instruction   (instruction),
    .instructionReg(instructionReg),
    .instrValid    (instrValid),
    .execDone      (execDone),
    .jumpTaken     (jumpTaken),
    .jumpTarget    (jumpTarget),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault),
    .instrCount    (instrCount)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    logic [7:0]  cnt;
  } issueT;

  typedef struct {
    logic [7:0] pc;
    int         delay;
    logic       jump;
    logic [7:0] target;
  } planT;

  issueT expQ[$];
  planT  planQ[$];
  planT  forcedQ[$];

  logic        expHalted;
  logic        expFault;
  logic [7:0]  expAddr;
  logic [7:0]  expCount;
  logic [15:0] expIr;
  logic        expIrKnown;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".address"},        32'(address),        32'd0);
    check({tag, ".instructionReg"}, 32'(instructionReg), 32'd0);
    check({tag, ".selectLatched"},  32'(selectLatched),  32'd0);
    check({tag, ".instrValid"},     32'(instrValid),     32'd0);
    check({tag, ".busy"},           32'(busy),           32'd0);
    check({tag, ".halted"},         32'(halted),         32'd0);
    check({tag, ".fault"},          32'(fault),          32'd0);
    check({tag, ".instrCount"},     32'(instrCount),     32'd0);
  endtask

  task automatic fillHalt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic forcePlan(input int delay, input logic jump, input logic [7:0] target);
    planT p;
    p.pc = 8'd0;
    p.delay = delay;
    p.jump = jump;
    p.target = target;
    forcedQ.push_back(p);
  endtask

  // Monitor: every instrValid pulse must match the head of the predicted stream.
  always @(negedge clk) begin
    if (instrValid) begin
      check("issueExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        issueT e;
        e = expQ.pop_front();
        check("instructionReg", 32'(instructionReg), 32'(e.word));
        check("issueAddress",   32'(address),        32'(e.pc));
        check("countAtIssue",   32'(instrCount),     32'(e.cnt));
      end
    end
  end

  // Reference model: walk the program as the execute stage will steer it.
  task automatic modelRun(input logic [7:0] sel);
    logic [7:0]  pc;
    logic [15:0] w;
    int          cnt;
    int          steps;
    planT        p;
    issueT       e;
    expQ.delete();
    planQ.delete();
    expIrKnown = 1'b1;
    if (sel == 8'd0) begin
      expHalted = 1'b1; expFault = 1'b1; expAddr = 8'd0; expCount = 8'd0;
      expIrKnown = 1'b0;
      forcedQ.delete();
      return;
    end
    pc = 8'd0; cnt = 0; steps = 0;
    while (1) begin
      w = mem[pc];
      if (w[15:12] == 4'hE) begin
        expHalted = 1'b1; expFault = 1'b0; expAddr = pc; expIr = w;
        break;
      end
      e.pc = pc; e.word = w; e.cnt = 8'(cnt);
      expQ.push_back(e);
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (forcedQ.size() > 0) begin
        p = forcedQ.pop_front();
      end else begin
        p.delay = int'($urandom_range(0, 3));
        if (steps >= 30) begin
          p.jump = 1'b1; p.target = 8'd200;
        end else begin
          p.jump = ($urandom_range(0, 3) == 0);
          p.target = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(252, 255));
        end
      end
      p.pc = pc;
      planQ.push_back(p);
      steps++;
      if (p.jump) begin
        pc = p.target;
      end else if (pc == 8'd255) begin
        expHalted = 1'b1; expFault = 1'b1; expAddr = 8'd255; expIr = w;
        break;
      end else begin
        pc = pc + 8'd1;
      end
    end
    expCount = 8'(cnt);
  endtask

  // Drive one program run, playing the execute stage from the model's plan.
  task automatic runProgram(input logic [7:0] sel, input int budget);
    int   cyc;
    int   countdown;
    int   lastIssue;
    int   lastDelay;
    logic done;
    planT cur;
    modelRun(sel);
    cur.pc = 8'd0; cur.delay = 0; cur.jump = 1'b0; cur.target = 8'd0;
    @(negedge clk);
    start = 1'b1;
    programSelect = sel;
    cyc = 0; countdown = -1; lastIssue = -1; lastDelay = 0; done = 1'b0;
    while (cyc < budget && !done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      programSelect = 8'($urandom);
      execDone = 1'b0;
      jumpTaken = 1'($urandom);
      jumpTarget = 8'($urandom);
      if (countdown >= 0) begin
        check("waitAddress",    32'(address),    32'(cur.pc));
        check("waitBusy",       32'(busy),       32'd1);
        check("waitInstrValid", 32'(instrValid), 32'd0);
      end
      if (countdown == 0) begin
        execDone = 1'b1;
        jumpTaken = cur.jump;
        jumpTarget = cur.target;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      if (instrValid) begin
        if (lastIssue < 0) check("firstIssueLatency", 32'(cyc), 32'd2);
        else check("issueGap", 32'(cyc - lastIssue), 32'(3 + lastDelay));
        check("planAvailable", 32'(planQ.size() != 0), 32'd1);
        if (planQ.size() != 0) cur = planQ.pop_front();
        lastIssue = cyc;
        lastDelay = cur.delay;
        countdown = cur.delay;
        // execDone during ISSUE must be ignored
        if ($urandom_range(0, 1) == 1) begin
          execDone = 1'b1;
          jumpTaken = 1'($urandom);
          jumpTarget = 8'($urandom);
        end
      end
      if (!busy) begin
        done = 1'b1;
        execDone = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
    end
    execDone = 1'b0;
    jumpTaken = 1'b0;
    start = 1'b0;
    check("runCompleted",   32'(done),          32'd1);
    check("finalHalted",    32'(halted),        32'(expHalted));
    check("finalFault",     32'(fault),         32'(expFault));
    check("finalAddress",   32'(address),       32'(expAddr));
    check("finalCount",     32'(instrCount),    32'(expCount));
    check("selectLatched",  32'(selectLatched), 32'(sel));
    check("pendingIssues",  32'(expQ.size()),   32'd0);
    check("finalNoValid",   32'(instrValid),    32'd0);
    if (expIrKnown) check("finalInstrReg", 32'(instructionReg), 32'(expIr));
  endtask

  initial begin
    logic found;
    issueT e;
    reset = 1'b1; start = 1'b0; execDone = 1'b0; jumpTaken = 1'b0;
    jumpTarget = 8'd0; programSelect = 8'd0;
    fillHalt();
    repeat (3) @(negedge clk);
    checkResetOutputs("powerOnReset");
    reset = 1'b0;

    // Two-word program: one instruction then HALT.
    fillHalt(); mem[0] = 16'h0102; mem[1] = 16'hE000;
    forcePlan(0, 1'b0, 8'd0);
    runProgram(8'h04, 100);

    // Same program with a long execute stall.
    forcePlan(10, 1'b0, 8'd0);
    runProgram(8'h04, 100);

    // Jump redirect to address 5.
    fillHalt(); mem[0] = 16'h1234;
    forcePlan(2, 1'b1, 8'h05);
    runProgram(8'h21, 100);

    // Jump to 255 then fall off the end of memory.
    fillHalt(); mem[0] = 16'h2222; mem[255] = 16'h3333;
    forcePlan(0, 1'b1, 8'hFF);
    forcePlan(1, 1'b0, 8'h00);
    runProgram(8'h7F, 100);

    // Null program select.
    runProgram(8'h00, 20);

    // Counter saturation: 300 self-jumps, then exit to a HALT word.
    fillHalt(); mem[0] = 16'h4444;
    for (int i = 0; i < 300; i++) forcePlan(0, 1'b1, 8'h00);
    forcePlan(0, 1'b1, 8'd200);
    runProgram(8'h11, 3000);

    // Random programs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[200] = 16'hE000;
      runProgram(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), 2000);
    end

    // Reset while waiting on the execute stage.
    fillHalt(); mem[0] = 16'h5678;
    expQ.delete();
    e.pc = 8'd0; e.word = 16'h5678; e.cnt = 8'd0;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b1; programSelect = 8'h33;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (instrValid) found = 1'b1;
    end
    check("resetTestIssued", 32'(found), 32'd1);
    @(negedge clk);
    check("resetTestInWait", 32'(busy), 32'd1);
    reset = 1'b1; start = 1'b1; execDone = 1'b1; jumpTaken = 1'b1; jumpTarget = 8'h10;
    @(negedge clk);
    checkResetOutputs("resetInWait");
    reset = 1'b0; start = 1'b0; execDone = 1'b0; jumpTaken = 1'b0;
    expQ.delete();

    // Restart from IDLE after the abort.
    fillHalt(); mem[0] = 16'h0102; mem[1] = 16'h0A0B;
    forcePlan(1, 1'b0, 8'd0);
    forcePlan(0, 1'b0, 8'd0);
    runProgram(8'h55, 100);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
